bsg_set_bit_enumerator: RTL and testbench

BSG_SET_BIT_ENUMERATOR -- requirements
Module: bsg_set_bit_enumerator

---
 rtl/bsg_set_bit_enumerator_pkg.sv | 9 +
 rtl/bsg_popcount.sv | 17 +
 rtl/bsg_set_bit_enumerator.sv | 101 ++++++++++
 tb/tb_bsg_set_bit_enumerator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_set_bit_enumerator_pkg.sv
// Shared types for the set-bit enumerator: controller state encoding.
package bsg_set_bit_enumerator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bsg_sbe_state_e;

endpackage

// File: rtl/bsg_popcount.sv
// Combinational population count of a width_p-bit vector.
module bsg_popcount #(
  parameter int width_p = 16,
  localparam int cnt_width_lp = $clog2(width_p) + 1
) (
  input  logic [width_p-1:0]      a_i,
  output logic [cnt_width_lp-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < width_p; i++) begin
      count_o = count_o + cnt_width_lp'(a_i[i]);
    end
  end

endmodule

// File: rtl/bsg_set_bit_enumerator.sv
// Accepts a vector and emits one beat per set bit, lowest index first.
// An all-zero vector yields a single beat flagged empty.
//
// state | meaning
// IDLE  | ready for a new vector, no beat presented
// BUSY  | presenting beats from the residual until the last one is taken
module bsg_set_bit_enumerator
  import bsg_set_bit_enumerator_pkg::*;
#(
  parameter int width_p = 16,
  localparam int lg_width_lp = $clog2(width_p),
  localparam int cnt_width_lp = $clog2(width_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [lg_width_lp-1:0]  idx_o,
  output logic                    empty_o,
  output logic                    last_o,
  output logic [cnt_width_lp-1:0] count_o,
  input  logic                    yumi_i
);

  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  bsg_sbe_state_e state_q, state_d;
  logic [width_p-1:0]      residual_q, residual_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic [cnt_width_lp-1:0] pop_cnt;
  logic [width_p-1:0]      low_bit, rest;
  logic [lg_width_lp-1:0]  low_idx;
  logic                    busy, last;

  bsg_popcount #(.width_p(width_p)) u_popcount (
    .a_i     (data_i),
    .count_o (pop_cnt)
  );

  // Isolate the lowest set bit, encode it, and form the residual without it.
  always_comb begin
    low_bit = residual_q & ~(residual_q - one_lp);
    rest    = residual_q & (residual_q - one_lp);
    low_idx = '0;
    for (int i = 0; i < width_p; i++) begin
      if (low_bit[i]) low_idx = low_idx | lg_width_lp'(i);
    end
  end

  assign busy = (state_q == BUSY);
  assign last = busy && (rest == '0);

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    count_d    = count_q;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          residual_d = data_i;
          count_d    = pop_cnt;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (yumi_i) begin
          residual_d = rest;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      residual_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      count_q    <= count_d;
    end
  end

  // Reset gates ready so nothing is accepted while the block is held.
  assign ready_o = (state_q == IDLE) && reset_n_i;
  assign v_o     = busy;
  assign idx_o   = low_idx;
  assign empty_o = busy && (residual_q == '0);
  assign last_o  = last;
  assign count_o = count_q;

  a_no_yumi_idle : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && (state_q == IDLE))
  );

endmodule

// File: tb/tb_bsg_set_bit_enumerator.sv
// Scoreboard bench: expected beats queued on acceptance, checked by a monitor.
module tb_bsg_set_bit_enumerator;

  typedef struct packed {
    logic [3:0] idx;
    logic       empty;
    logic       last;
    logic [4:0] count;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ready_o, v_o, empty_o, last_o;
  logic [3:0]  idx_o;
  logic [4:0]  count_o;
  logic        yumi_i = 1'b0;
  logic        yumi_en = 1'b1;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];

  bsg_set_bit_enumerator #(.width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .idx_o     (idx_o),
    .empty_o   (empty_o),
    .last_o    (last_o),
    .count_o   (count_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer: take every presented beat unless stalled via yumi_en.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      yumi_i = yumi_en && v_o && reset_n_i;
    end
  end

  // Monitor: compare every presented beat (including stalled repeats).
  initial begin
    beat_t got, exp;
    forever begin
      @(negedge clk_i);
      if (reset_n_i && v_o) begin
        checks++;
        if (ready_o) begin
          errors++;
          $display("FAIL ready_while_busy actual=%0b required=0", ready_o);
        end
        got = {idx_o, empty_o, last_o, count_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual idx=%0d empty=%0b last=%0b count=%0d required=no beat",
                   idx_o, empty_o, last_o, count_o);
        end else begin
          exp = exp_q[0];
          if (got !== exp) begin
            errors++;
            $display("FAIL beat actual idx=%0d empty=%0b last=%0b count=%0d required idx=%0d empty=%0b last=%0b count=%0d",
                     got.idx, got.empty, got.last, got.count, exp.idx, exp.empty, exp.last, exp.count);
          end
          if (yumi_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected beats: set bits in ascending order, last flagged on the hc-th one.
  task automatic push_vec(input logic [15:0] d, input int hc);
    beat_t b;
    int n = 0;
    if (d == 16'h0000) begin
      b = '{idx: 4'd0, empty: 1'b1, last: 1'b1, count: 5'd0};
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (d[i]) begin
          n++;
          b = '{idx: 4'(i), empty: 1'b0, last: (n == hc), count: 5'(hc)};
          exp_q.push_back(b);
        end
      end
    end
  endtask

  function automatic int ref_pop(input logic [15:0] d);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(d[i]);
    return n;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] d, input int hc);
    bit ok = 1'b0;
    v_i = 1'b1;
    data_i = d;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk_i);
      if (ready_o) begin
        push_vec(d, hc);
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !v_o) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int cyc;
    logic [15:0] d;

    @(negedge clk_i);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // All-zero vector: single empty beat.
    send(16'h0000, 0);
    v_i = 1'b0;
    drain();

    // Sparse vector with continuous consumption; ready returns on cycle 5.
    send(16'h8421, 4);
    v_i = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (ready_o && cyc == 0) cyc = k;
    end
    chk("ready_cycle_8421", 32'(cyc), 32'd5);
    @(posedge clk_i);
    #1;
    drain();

    // All-ones vector: count saturates into the MSB.
    send(16'hFFFF, 16);
    v_i = 1'b0;
    drain();

    // Stall: idx 8 presented for 3 cycles before being taken.
    yumi_en = 1'b0;
    send(16'h0300, 2);
    v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    yumi_en = 1'b1;
    drain();

    // Reset after the second beat discards the rest.
    send(16'h00F0, 4);
    v_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("midrst_v", 32'(v_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    chk("midrst_last", 32'(last_o), 32'd0);
    chk("midrst_count", 32'(count_o), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready_after", 32'(ready_o), 32'd1);
    chk("midrst_v_after", 32'(v_o), 32'd0);
    @(posedge clk_i);
    #1;
    send(16'h0001, 1);
    v_i = 1'b0;
    drain();

    // v_i held high with a stream of random vectors.
    for (int k = 0; k < 24; k++) begin
      d = 16'($urandom);
      if (k % 7 == 3) d = 16'h0000;
      send(d, ref_pop(d));
    end
    v_i = 1'b0;
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
